// File: rtl/br_lite_local_ni.sv
// BrLite local network interface: PE valid/ready <-> router 4-phase req/ack.
// TX builds and injects broadcast flits; RX buffers delivered flits in a FIFO.
package BrLitePkg;
  localparam int BR_PAYLOAD_W = 32;
  localparam int BR_ID_W = 4;

  typedef enum logic [1:0] {
    BR_SVC_TGT   = 2'd0,
    BR_SVC_ALL   = 2'd1,
    BR_SVC_CLEAR = 2'd2,
    BR_SVC_RSVD  = 2'd3
  } br_svc_t;

  typedef struct packed {
    logic [BR_PAYLOAD_W-1:0] payload;
    logic [BR_ID_W-1:0]      id;
    br_svc_t                 service;
    logic [15:0]             target;
    logic [15:0]             source;
  } br_data_t;
endpackage

module br_lite_local_ni
  import BrLitePkg::*;
#(
  parameter logic [15:0] ADDRESS = 16'h0000,
  parameter int RX_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    tx_valid_i,
  output logic                    tx_ready_o,
  input  logic [15:0]             tx_target_i,
  input  br_svc_t                 tx_service_i,
  input  logic [BR_PAYLOAD_W-1:0] tx_payload_i,
  output logic                    tx_err_o,
  input  logic                    busy_i,
  output br_data_t                flit_o,
  output logic                    req_o,
  input  logic                    ack_i,
  input  br_data_t                flit_i,
  input  logic                    req_i,
  output logic                    ack_o,
  output logic                    rx_valid_o,
  input  logic                    rx_ready_i,
  output br_data_t                rx_data_o,
  output logic [$clog2(RX_DEPTH):0] rx_count_o
);

  localparam int PTR_W = $clog2(RX_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_REQ,
    TX_RELEASE
  } tx_state_e;

  typedef enum logic {
    RX_IDLE,
    RX_ACK
  } rx_state_e;

  tx_state_e          tx_q, tx_d;
  br_data_t           flit_q, flit_d;
  logic [BR_ID_W-1:0] id_q, id_d;
  logic               err_q, err_d;
  logic               run_q;

  rx_state_e          rx_q, rx_d;
  br_data_t           mem [RX_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push, pop, full;

  always_comb begin
    tx_d       = tx_q;
    flit_d     = flit_q;
    id_d       = id_q;
    err_d      = 1'b0;
    tx_ready_o = 1'b0;
    req_o      = 1'b0;
    unique case (tx_q)
      TX_IDLE: begin
        tx_ready_o = run_q && !busy_i;
        if (tx_valid_i && tx_ready_o) begin
          flit_d = '{
            payload: tx_payload_i,
            id:      id_q,
            service: tx_service_i,
            target:  tx_target_i,
            source:  ADDRESS
          };
          if (tx_service_i == BR_SVC_CLEAR) begin
            err_d = 1'b1;
          end else begin
            tx_d = TX_REQ;
          end
        end
      end
      TX_REQ: begin
        req_o = 1'b1;
        if (ack_i) tx_d = TX_RELEASE;
      end
      TX_RELEASE: begin
        // waiting for ack low covers both pulsed and held acks
        if (!ack_i) begin
          id_d = id_q + 1'b1;
          tx_d = TX_IDLE;
        end
      end
      default: tx_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_q   <= TX_IDLE;
      flit_q <= '0;
      id_q   <= '0;
      err_q  <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      flit_q <= flit_d;
      id_q   <= id_d;
      err_q  <= err_d;
      run_q  <= 1'b1;
    end
  end

  assign flit_o   = flit_q;
  assign tx_err_o = err_q;

  // full is taken before any same-cycle pop
  assign full       = count == CNT_W'(RX_DEPTH);
  assign rx_valid_o = count != '0;
  assign pop        = rx_valid_o && rx_ready_i;

  always_comb begin
    rx_d = rx_q;
    push = 1'b0;
    unique case (rx_q)
      RX_IDLE: begin
        if (req_i && !full) begin
          push = 1'b1;
          rx_d = RX_ACK;
        end
      end
      RX_ACK: begin
        if (!req_i) rx_d = RX_IDLE;
      end
      default: rx_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_q   <= RX_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      rx_q <= rx_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= flit_i;
  end

  assign ack_o      = rx_q == RX_ACK;
  assign rx_count_o = count;
  assign rx_data_o  = rx_valid_o ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_br_lite_local_ni.sv
// Scoreboard bench for br_lite_local_ni: router TX responder,
// router RX delivery tasks and an RX FIFO monitor.
module tb_br_lite_local_ni;
  import BrLitePkg::*;

  localparam logic [15:0] ADDR = 16'hA5C3;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_ni;
  logic tx_valid, tx_ready, tx_err, busy;
  logic [15:0] tx_target;
  br_svc_t tx_service;
  logic [31:0] tx_payload;
  br_data_t flit_o, flit_i, rx_data;
  logic req_o, ack_i, req_i, ack_o;
  logic rx_valid, rx_ready;
  logic [$clog2(DEPTH):0] rx_count;

  int checks = 0;
  int failures = 0;
  br_data_t tx_exp[$];
  br_data_t rx_exp[$];
  logic [BR_ID_W-1:0] exp_id = '0;
  bit tx_auto = 1'b0;
  bit tx_held = 1'b0;
  int tx_dly = 2;

  always #5 clk = ~clk;

  br_lite_local_ni #(.ADDRESS(ADDR), .RX_DEPTH(DEPTH)) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready),
    .tx_target_i(tx_target),
    .tx_service_i(tx_service),
    .tx_payload_i(tx_payload),
    .tx_err_o(tx_err),
    .busy_i(busy),
    .flit_o(flit_o),
    .req_o(req_o),
    .ack_i(ack_i),
    .flit_i(flit_i),
    .req_i(req_i),
    .ack_o(ack_o),
    .rx_valid_o(rx_valid),
    .rx_ready_i(rx_ready),
    .rx_data_o(rx_data),
    .rx_count_o(rx_count)
  );

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // router local input: checks the flit, then acks
  initial begin
    br_data_t e;
    ack_i = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_auto && rst_ni && req_o && !ack_i) begin
        if (tx_exp.size() == 0) begin
          fail("tx_unexpected_req");
        end else begin
          e = tx_exp.pop_front();
          chk("tx_flit", flit_o, e);
        end
        repeat (tx_dly) begin
          @(negedge clk);
          chk("tx_req_hold", req_o, 1'b1);
        end
        ack_i = 1'b1;
        @(negedge clk);
        chk("tx_req_fall", req_o, 1'b0);
        if (tx_held) @(negedge clk);
        ack_i = 1'b0;
      end
    end
  end

  // RX FIFO monitor
  initial begin
    br_data_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_ni && rx_valid && rx_ready) begin
        if (rx_exp.size() == 0) begin
          fail("rx_unexpected_pop");
        end else begin
          e = rx_exp.pop_front();
          chk("rx_data", rx_data, e);
        end
      end
    end
  end

  task automatic send(input logic [15:0] tgt, input br_svc_t svc,
                      input logic [31:0] pl);
    br_data_t e;
    int n;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_target = tgt;
    tx_service = svc;
    tx_payload = pl;
    n = 0;
    while (!tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      chk("tx_accept_timeout", tx_ready, 1'b1);
      tx_valid = 1'b0;
      return;
    end
    e = '{payload: pl, id: exp_id, service: svc,
          target: tgt, source: ADDR};
    if (svc != BR_SVC_CLEAR) begin
      tx_exp.push_back(e);
      exp_id++;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    if (svc == BR_SVC_CLEAR) begin
      chk("tx_err_pulse", tx_err, 1'b1);
      chk("tx_clear_noreq", req_o, 1'b0);
      @(negedge clk);
      chk("tx_err_drop", tx_err, 1'b0);
      chk("tx_clear_noreq2", req_o, 1'b0);
    end
  endtask

  task automatic wait_tx_done();
    int n;
    n = 0;
    while ((tx_exp.size() != 0 || !tx_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tx_drain", tx_exp.size() == 0 && tx_ready, 1'b1);
  endtask

  task automatic deliver(input br_data_t f, input bit bcast);
    int n;
    @(negedge clk);
    flit_i = f;
    req_i = 1'b1;
    rx_exp.push_back(f);
    n = 0;
    while (!ack_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rx_ack_rise", ack_o, 1'b1);
    if (bcast) begin
      @(negedge clk);
      chk("rx_ack_hold", ack_o, 1'b1);
    end
    req_i = 1'b0;
    @(negedge clk);
    chk("rx_ack_fall", ack_o, 1'b0);
  endtask

  task automatic drain();
    int n;
    @(negedge clk);
    rx_ready = 1'b1;
    n = 0;
    while (rx_count != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    rx_ready = 1'b0;
    chk("rx_drain_count", rx_count, 0);
    chk("rx_drain_queue", rx_exp.size(), 0);
  endtask

  function automatic br_data_t mk(input logic [15:0] src,
                                  input logic [31:0] pl);
    br_data_t f;
    f = '{payload: pl, id: pl[3:0], service: BR_SVC_ALL,
          target: 16'h0000, source: src};
    return f;
  endfunction

  initial begin
    rst_ni = 1'b0;
    tx_valid = 1'b0;
    tx_target = '0;
    tx_service = BR_SVC_TGT;
    tx_payload = '0;
    busy = 1'b0;
    flit_i = '0;
    req_i = 1'b0;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", tx_ready, 1'b0);
    chk("rst_tx_err", tx_err, 1'b0);
    chk("rst_req", req_o, 1'b0);
    chk("rst_ack", ack_o, 1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_count", rx_count, 0);
    chk("rst_flit", flit_o, 0);
    chk("rst_rx_data", rx_data, 0);
    rst_ni = 1'b1;
    tx_auto = 1'b1;

    // TX basic: pulsed ack then held ack
    send(16'h0102, BR_SVC_TGT, 32'd5);
    wait_tx_done();
    tx_held = 1'b1;
    send(16'h0304, BR_SVC_ALL, 32'hDEADBEEF);
    wait_tx_done();
    tx_held = 1'b0;

    // busy gating
    @(negedge clk);
    busy = 1'b1;
    tx_valid = 1'b1;
    tx_target = 16'h0BEE;
    tx_service = BR_SVC_ALL;
    tx_payload = 32'h1234;
    repeat (20) begin
      @(negedge clk);
      chk("busy_ready", tx_ready, 1'b0);
      chk("busy_req", req_o, 1'b0);
    end
    tx_exp.push_back('{payload: 32'h1234, id: exp_id,
                       service: BR_SVC_ALL, target: 16'h0BEE,
                       source: ADDR});
    exp_id++;
    busy = 1'b0;
    #1;
    chk("busy_ready_same", tx_ready, 1'b1);
    @(negedge clk);
    tx_valid = 1'b0;
    chk("busy_req_next", req_o, 1'b1);
    wait_tx_done();

    // CLEAR reject, id must not advance
    send(16'h0055, BR_SVC_CLEAR, 32'd7);
    send(16'h0066, BR_SVC_TGT, 32'd9);
    wait_tx_done();

    // RX: targeted then broadcast delivery
    deliver(mk(16'h0011, 32'h11), 1'b0);
    chk("rx_count_1", rx_count, 1);
    deliver(mk(16'h0022, 32'h22), 1'b1);
    chk("rx_count_2", rx_count, 2);
    drain();

    // full backpressure
    deliver(mk(16'h0031, 32'h31), 1'b0);
    deliver(mk(16'h0032, 32'h32), 1'b1);
    deliver(mk(16'h0033, 32'h33), 1'b0);
    deliver(mk(16'h0034, 32'h34), 1'b1);
    chk("rx_full_count", rx_count, 4);
    @(negedge clk);
    flit_i = mk(16'h0035, 32'h35);
    req_i = 1'b1;
    rx_exp.push_back(flit_i);
    repeat (8) begin
      @(negedge clk);
      chk("rx_full_noack", ack_o, 1'b0);
    end
    chk("rx_full_count2", rx_count, 4);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    begin
      int n;
      n = 0;
      while (!ack_o && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("rx_fifth_ack", ack_o, 1'b1);
    chk("rx_refill_count", rx_count, 4);
    req_i = 1'b0;
    @(negedge clk);
    chk("rx_fifth_ack_fall", ack_o, 1'b0);
    drain();

    // reset during TX_REQ and RX_ACK
    tx_auto = 1'b0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_target = 16'h0777;
    tx_service = BR_SVC_TGT;
    tx_payload = 32'h77;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("rst_mid_req_up", req_o, 1'b1);
    flit_i = mk(16'h0088, 32'h88);
    req_i = 1'b1;
    @(negedge clk);
    chk("rst_mid_ack_up", ack_o, 1'b1);
    chk("rst_mid_count", rx_count, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_async_req", req_o, 1'b0);
    chk("rst_async_ack", ack_o, 1'b0);
    chk("rst_async_count", rx_count, 0);
    chk("rst_async_valid", rx_valid, 1'b0);
    chk("rst_async_ready", tx_ready, 1'b0);
    req_i = 1'b0;
    tx_exp.delete();
    rx_exp.delete();
    exp_id = '0;
    @(negedge clk);
    rst_ni = 1'b1;
    tx_auto = 1'b1;

    // id wrap: 2^BR_ID_W + 1 messages, last id is 0 again
    tx_dly = 0;
    for (int i = 0; i <= (1 << BR_ID_W); i++) begin
      send(16'(i), BR_SVC_TGT, 32'(i + 100));
    end
    wait_tx_done();
    chk("id_wrap_last", flit_o.id, 0);

    repeat (3) @(negedge clk);
    chk("tx_queue_empty", tx_exp.size(), 0);
    chk("rx_queue_empty", rx_exp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/br_lite_local_ni.md
Name: br_lite_local_ni

Overview:
- Local network interface between a PE and the local port of a BrLite router.
- TX side: takes PE broadcast requests on a valid/ready interface, builds a br_data_t flit with source = ADDRESS and an auto-incrementing id, and injects it with a 4-phase req/ack handshake into the router's local input.
- RX side: accepts flits delivered on the router's local output, acknowledges them, and buffers them in a FIFO that the PE drains via valid/ready.

Parameters:
ADDRESS, 16'h0000, PE address written into the flit source field.
RX_DEPTH, 4, RX FIFO depth in entries; power of two, >= 2.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  reset.
tx_valid_i  in  1  PE has a message to broadcast.
tx_ready_o  out  1  NI accepts the message this cycle.
tx_target_i  in  16  flit target field.
tx_service_i  in  br_svc_t  flit service field.
tx_payload_i  in  payload width from BrLitePkg  flit payload field.
tx_err_o  out  1  one-cycle pulse: accepted request was rejected.
busy_i  in  1  router local_busy_o.
flit_o  out  br_data_t  flit to router local input.
req_o  out  1  request to router local input.
ack_i  in  1  ack from router local input.
flit_i  in  br_data_t  flit from router local output.
req_i  in  1  request from router local output.
ack_o  out  1  ack to router local output.
rx_valid_o  out  1  FIFO head valid.
rx_ready_i  in  1  PE pops the FIFO head.
rx_data_o  out  br_data_t  FIFO head flit.
rx_count_o  out  $clog2(RX_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: rst_ni, asynchronous, active-low; clock clk_i. All outputs are 0 in reset: tx_ready_o, tx_err_o, req_o, ack_o, rx_valid_o, rx_count_o; flit_o, rx_data_o = '0. Reset also clears the id counter, the TX FSM (TX_IDLE), the RX FSM (RX_IDLE) and the FIFO pointers. Reset mid-handshake aborts it; no retry.
- TX FSM states: TX_IDLE, TX_REQ, TX_RELEASE.
- TX_IDLE:
  - tx_ready_o = !busy_i (combinational; only in TX_IDLE).
  - On tx_valid_i && tx_ready_o, register the flit: source=ADDRESS, target, service, payload, id = id counter.
  - If tx_service_i == BR_SVC_CLEAR: pulse tx_err_o next cycle, stay in TX_IDLE, id unchanged.
  - Otherwise go to TX_REQ.
- TX_REQ:
  - req_o = 1; flit_o holds the registered flit.
  - Wait indefinitely for ack_i. A CAM-full drop in the router is not acked, so req_o stays high until the router re-arbitrates and acks.
  - On ack_i = 1, go to TX_RELEASE.
- TX_RELEASE:
  - req_o = 0.
  - When ack_i = 0, increment id (wraps modulo id field width) and go to TX_IDLE.
- TX handshake rules:
  - Both the 1-cycle ack and the held-ack router responses are handled by waiting for ack low.
  - Min TX cycle: 3 clocks plus router latency.
  - flit_o is stable from TX_REQ entry until the return to TX_IDLE.
- RX FSM states: RX_IDLE, RX_ACK.
- RX_IDLE:
  - On req_i && count < RX_DEPTH: write flit_i at wr_ptr, go to RX_ACK. ack_o is registered and rises the next cycle.
  - If the FIFO is full, ack_o stays 0 (backpressure) and req_i is held pending.
- RX_ACK:
  - ack_o = 1 until req_i is sampled 0.
  - ack_o is 0 in the cycle after req_i is sampled 0, then the FSM returns to RX_IDLE.
  - This covers both router delivery modes: targeted delivery (req drops after ack) and broadcast delivery (req drops one cycle after the ack is registered).
- RX guarantees: exactly one FIFO write per handshake; no write while in RX_ACK.
- FIFO:
  - rx_valid_o = count != 0; rx_data_o = entry at rd_ptr.
  - Pop on rx_valid_o && rx_ready_i.
  - Pointers wrap modulo RX_DEPTH.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Full is evaluated before the same-cycle pop (no bypass).
  - Pop on empty is ignored.
- No flit filtering: every flit the router delivers is stored.

Test Plan:
- TX basic: tx_valid, target=16'h0102, service=BR_SVC_TGT, payload=5, router acks 2 cycles after req → flit_o.source=ADDRESS, id=0, req_o falls the cycle after ack; second message carries id=1.
- busy gating: busy_i=1 with tx_valid_i=1 for 20 cycles → tx_ready_o=0 and req_o=0 throughout; busy_i drops → accepted in the same cycle, req_o rises the next cycle.
- CLEAR reject and id wrap: service=BR_SVC_CLEAR → tx_err_o pulses once, no req_o, id unchanged. Inject 2^idwidth+1 messages → last id=0.
- RX both modes: targeted delivery (router holds req until ack) and broadcast delivery (req drops one cycle after ack) → one FIFO entry per handshake; ack_o low exactly 1 cycle after req_i low.
- Full backpressure: RX_DEPTH=4, rx_ready_i=0, 5 deliveries → 4 acked, 5th req_i unacked, rx_count_o=4. Pop one → 5th acked, count=4, data order preserved.
- Reset mid-op: assert rst_ni=0 during TX_REQ and RX_ACK → req_o=0, ack_o=0, rx_count_o=0 immediately (async), id=0 after release.
